// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program-memory instruction fetcher with ready/valid issue and single-step support
module instr_fetch #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] last_addr,
    input  logic          step_mode,
    input  logic          step,
    output logic [DW-1:0] sig,
    output logic          sig_valid,
    input  logic          sig_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_STEP = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] pc_q;
    logic [AW-1:0] last_lat;
    logic [DW-1:0] sig_q;
    logic          at_rest;
    logic          accept;
    logic          is_last;

    assign at_rest = (state == S_IDLE) || (state == S_DONE);
    assign accept  = (state == S_ISSUE) && sig_ready;
    assign is_last = (pc_q == last_lat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (sig_ready) begin
                    if (is_last) begin
                        state_nx = S_DONE;
                    end else if (step_mode) begin
                        state_nx = S_WAIT_STEP;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end
            end
            S_WAIT_STEP: begin
                if (step) begin
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sig_valid = (state == S_ISSUE);
        busy      = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT_STEP);
        done      = (state == S_DONE);
    end

    // Program memory has no reset so a program survives rst_n; loads only land while at rest.
    always_ff @(posedge clk) begin
        if (rst_n && at_rest && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= '0;
            last_lat <= '0;
            sig_q    <= '0;
        end else begin
            if (at_rest && start) begin
                pc_q     <= '0;
                last_lat <= last_addr;
            end else if (accept && !is_last) begin
                pc_q <= pc_q + 1'b1;
            end
            if (state == S_FETCH) begin
                sig_q <= mem[pc_q];
            end
        end
    end

    assign sig = sig_q;
    assign pc  = pc_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning the program-memory address width (2^AW entries).
REQ-002 The block SHALL have parameter DW, default 8, meaning the instruction width, which matches the downstream processor's 8-bit sig bus.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port load_en, input, 1 bit: program-memory write strobe.
REQ-006 The block SHALL have port load_addr, input, AW bits: program-memory write address.
REQ-007 The block SHALL have port load_data, input, DW bits: program-memory write data.
REQ-008 The block SHALL have port start, input, 1 bit: begin program execution at address 0.
REQ-009 The block SHALL have port last_addr, input, AW bits: address of the final instruction, sampled on an accepted start.
REQ-010 The block SHALL have port step_mode, input, 1 bit: when 1, pause after each issued instruction.
REQ-011 The block SHALL have port step, input, 1 bit: single-step advance pulse.
REQ-012 The block SHALL have port sig, output, DW bits: instruction to the processor.
REQ-013 The block SHALL have port sig_valid, output, 1 bit: sig holds a valid instruction.
REQ-014 The block SHALL have port sig_ready, input, 1 bit: the processor accepts sig this cycle.
REQ-015 The block SHALL have port pc, output, AW bits: address of the current instruction.
REQ-016 The block SHALL have port busy, output, 1 bit: 1 in FETCH, ISSUE and WAIT_STEP.
REQ-017 The block SHALL have port done, output, 1 bit: 1 in state DONE.

Function
REQ-018 The program memory SHALL be 2^AW x DW; it is written at load_addr with load_data on a clock edge with load_en=1 only in IDLE or DONE, and load_en is ignored otherwise.
REQ-019 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT_STEP, DONE.
REQ-020 In IDLE or DONE, start=1 SHALL set pc=0, latch last_addr into last_lat, clear done, and go to FETCH.
REQ-021 FETCH SHALL register mem[pc] into sig and go to ISSUE unconditionally (one cycle).
REQ-022 In ISSUE, sig_valid SHALL be 1 and sig and pc SHALL be held stable until a cycle with sig_ready=1.
REQ-023 On an ISSUE cycle with sig_ready=1 and pc==last_lat, the FSM SHALL go to DONE with pc unchanged.
REQ-024 On an ISSUE cycle with sig_ready=1 and pc!=last_lat, pc SHALL increment by 1 and the FSM SHALL go to WAIT_STEP if step_mode=1, else to FETCH.
REQ-025 WAIT_STEP SHALL go to FETCH on step=1 and otherwise hold; step is ignored in every other state.
REQ-026 sig_valid SHALL be 0 in all states other than ISSUE; sig SHALL retain its last value outside ISSUE.
REQ-027 Latency SHALL be: start accepted at edge N gives sig_valid=1 from cycle N+2; with sig_ready tied 1 and step_mode=0, one instruction is issued every 2 cycles.
REQ-028 pc SHALL never wrap, because execution ends at last_lat; last_addr=0 SHALL run exactly one instruction.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 A load_en write and a start in the same IDLE cycle SHALL both take effect, and the subsequent FETCH SHALL read the newly written data.
REQ-031 A step_mode change SHALL take effect at the next ISSUE acceptance.

Reset
REQ-032 On a clock edge with rst_n=0, in any state including mid-program, the block SHALL enter IDLE with pc=0, sig=0, sig_valid=0, done=0, busy=0, and last_lat=0.
REQ-033 Program memory contents SHALL be unaffected by reset.

Verification
REQ-034 Load mem[0..3]=8'h5A,8'h13,8'h00,8'hF2, then start with last_addr=3, step_mode=0, sig_ready=1 -> sig_valid pulses on cycles 2,4,6,8 after start with sig 5A,13,00,F2, then done=1, pc=3.
REQ-035 Same program with sig_ready held 0 for 3 cycles during the second ISSUE -> sig stays 8'h13, pc stays 1, sig_valid stays 1, and no instruction is skipped or duplicated.
REQ-036 step_mode=1, last_addr=2 -> after each acceptance the FSM waits in WAIT_STEP with sig_valid=0; step pulses advance the FSM; the step pulse before start is ignored; done=1 after the third acceptance.
REQ-037 last_addr=0 -> exactly one sig_valid acceptance of mem[0], then done=1; start re-asserted while busy is ignored; start from DONE restarts at pc=0.
REQ-038 rst_n=0 during the ISSUE of pc=2 -> the next cycle is IDLE with sig_valid=0, pc=0, sig=0; a restart afterwards replays from mem[0] with unchanged memory contents.
REQ-039 load_en to address 1 during busy -> memory is unchanged; load_en plus start in the same IDLE cycle at address 0 -> the first issued sig equals the new data.
